// File: rtl/mult_sweep_pkg.sv
// Shared types and constants for the multiplier sweep checker.
package mult_sweep_pkg;

  localparam int unsigned SETTLE_W = 8;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StSettle = 2'd1,
    StCheck  = 2'd2,
    StDone   = 2'd3
  } sweep_state_e;

endpackage

// File: rtl/mult_sweep_operand_gen.sv
// Exhaustive operand counter: b is the low half of {a,b}, so it increments fastest.
module mult_sweep_operand_gen #(
  parameter int unsigned WIDTH_A = 2,
  parameter int unsigned WIDTH_B = 2
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_clear,
  input  logic               i_advance,
  output logic [WIDTH_A-1:0] o_a,
  output logic [WIDTH_B-1:0] o_b,
  output logic               o_last
);

  localparam int unsigned W = WIDTH_A + WIDTH_B;

  logic [W-1:0] r_ab;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_ab <= '0;
    end else if (i_clear) begin
      r_ab <= '0;
    end else if (i_advance) begin
      r_ab <= r_ab + W'(1);
    end
  end

  assign o_a    = r_ab[W-1:WIDTH_B];
  assign o_b    = r_ab[WIDTH_B-1:0];
  assign o_last = &r_ab;

endmodule

// File: rtl/mult_sweep_checker.sv
// Sweeps every (a,b) pair into the fabric multiplier, waits SETTLE cycles,
// checks z against a*b and records the error count and first mismatch.
module mult_sweep_checker
  import mult_sweep_pkg::*;
#(
  parameter int unsigned WIDTH_A = 2,
  parameter int unsigned WIDTH_B = 2,
  parameter int unsigned SETTLE  = 2
) (
  input  logic                       clk,
  input  logic                       global_resetn,
  input  logic                       start,
  input  logic                       abort,
  input  logic [WIDTH_A+WIDTH_B-1:0] z,
  output logic [WIDTH_A-1:0]         a,
  output logic [WIDTH_B-1:0]         b,
  output logic                       busy,
  output logic                       done,
  output logic                       pass,
  output logic [WIDTH_A+WIDTH_B:0]   err_count,
  output logic                       fail_seen,
  output logic [WIDTH_A-1:0]         fail_a,
  output logic [WIDTH_B-1:0]         fail_b,
  output logic [WIDTH_A+WIDTH_B-1:0] fail_z
);

  localparam int unsigned W = WIDTH_A + WIDTH_B;
  localparam logic [SETTLE_W-1:0] Reload = SETTLE_W'(SETTLE - 1);

  sweep_state_e        r_state, w_state_next;
  logic [SETTLE_W-1:0] r_cnt, w_cnt_next;
  logic                w_clear, w_advance, w_last;
  logic                w_start_acc, w_check, w_mismatch;
  logic [W-1:0]        w_expected;

  logic [W:0]          r_err;
  logic                r_fail_seen;
  logic [WIDTH_A-1:0]  r_fail_a;
  logic [WIDTH_B-1:0]  r_fail_b;
  logic [W-1:0]        r_fail_z;

  mult_sweep_operand_gen #(
    .WIDTH_A (WIDTH_A),
    .WIDTH_B (WIDTH_B)
  ) u_operand_gen (
    .i_clk     (clk),
    .i_rst_n   (global_resetn),
    .i_clear   (w_clear),
    .i_advance (w_advance),
    .o_a       (a),
    .o_b       (b),
    .o_last    (w_last)
  );

  // abort outranks everything, including a simultaneous start
  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_clear      = 1'b0;
    w_advance    = 1'b0;
    if (abort) begin
      w_state_next = StIdle;
      w_cnt_next   = '0;
      w_clear      = 1'b1;
    end else begin
      unique case (r_state)
        StIdle, StDone: begin
          if (start) begin
            w_clear      = 1'b1;
            w_cnt_next   = Reload;
            w_state_next = StSettle;
          end
        end
        StSettle: begin
          if (r_cnt == '0) begin
            w_state_next = StCheck;
          end else begin
            w_cnt_next = r_cnt - SETTLE_W'(1);
          end
        end
        StCheck: begin
          if (w_last) begin
            w_state_next = StDone;
          end else begin
            w_advance    = 1'b1;
            w_cnt_next   = Reload;
            w_state_next = StSettle;
          end
        end
        default: w_state_next = StIdle;
      endcase
    end
  end

  assign w_start_acc = !abort && start && ((r_state == StIdle) || (r_state == StDone));
  assign w_check     = !abort && (r_state == StCheck);
  assign w_expected  = W'(a) * W'(b);
  assign w_mismatch  = (z != w_expected);

  always_ff @(posedge clk or negedge global_resetn) begin
    if (!global_resetn) begin
      r_state <= StIdle;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
    end
  end

  always_ff @(posedge clk or negedge global_resetn) begin
    if (!global_resetn) begin
      r_err       <= '0;
      r_fail_seen <= 1'b0;
      r_fail_a    <= '0;
      r_fail_b    <= '0;
      r_fail_z    <= '0;
    end else if (w_start_acc) begin
      r_err       <= '0;
      r_fail_seen <= 1'b0;
      r_fail_a    <= '0;
      r_fail_b    <= '0;
      r_fail_z    <= '0;
    end else if (w_check && w_mismatch) begin
      r_err <= r_err + (W+1)'(1);
      if (!r_fail_seen) begin
        r_fail_seen <= 1'b1;
        r_fail_a    <= a;
        r_fail_b    <= b;
        r_fail_z    <= z;
      end
    end
  end

  assign busy      = (r_state == StSettle) || (r_state == StCheck);
  assign done      = (r_state == StDone);
  assign pass      = done && (r_err == '0);
  assign err_count = r_err;
  assign fail_seen = r_fail_seen;
  assign fail_a    = r_fail_a;
  assign fail_b    = r_fail_b;
  assign fail_z    = r_fail_z;

endmodule

// File: tb/tb_mult_sweep_checker.sv
// Directed bench: default-parameter checker with a fault-injectable ideal multiplier,
// plus a SETTLE=1 instance fed by a one-cycle-delayed multiplier.
module tb_mult_sweep_checker;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start, abort;
  logic [3:0] z, prod;
  logic [1:0] a, b, fail_a, fail_b;
  logic       busy, done, pass, fail_seen;
  logic [4:0] err;
  logic [3:0] fail_z;

  logic       start2, abort2;
  logic [3:0] z2;
  logic [1:0] a2, b2, fail_a2, fail_b2;
  logic       busy2, done2, pass2, fail_seen2;
  logic [4:0] err2;
  logic [3:0] fail_z2;

  int mode;
  int checks = 0;
  int errors = 0;
  int cyc, seq_bad;

  always #5 clk = ~clk;

  mult_sweep_checker #(.WIDTH_A(2), .WIDTH_B(2), .SETTLE(2)) dut (
    .clk (clk), .global_resetn (rst_n), .start (start), .abort (abort), .z (z),
    .a (a), .b (b), .busy (busy), .done (done), .pass (pass), .err_count (err),
    .fail_seen (fail_seen), .fail_a (fail_a), .fail_b (fail_b), .fail_z (fail_z)
  );

  mult_sweep_checker #(.WIDTH_A(2), .WIDTH_B(2), .SETTLE(1)) dut1 (
    .clk (clk), .global_resetn (rst_n), .start (start2), .abort (abort2), .z (z2),
    .a (a2), .b (b2), .busy (busy2), .done (done2), .pass (pass2), .err_count (err2),
    .fail_seen (fail_seen2), .fail_a (fail_a2), .fail_b (fail_b2), .fail_z (fail_z2)
  );

  // mode 0: ideal, 1: z[3] stuck-at-0, 2: z[0] stuck-at-1
  always_comb begin
    prod = {2'b00, a} * {2'b00, b};
    z    = prod;
    if (mode == 1) z[3] = 1'b0;
    else if (mode == 2) z[0] = 1'b1;
  end

  always @(posedge clk) z2 <= {2'b00, a2} * {2'b00, b2};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ab"}, {28'd0, a, b}, 32'd0);
    check({tag, "_flags"}, {28'd0, busy, done, pass, fail_seen}, 32'd0);
    check({tag, "_err"}, {27'd0, err}, 32'd0);
    check({tag, "_fail"}, {24'd0, fail_a, fail_b, fail_z}, 32'd0);
  endtask

  // Cycle n after the accept edge should present vector n/3 with busy high.
  task automatic run_sweep(input int restart_at, output int n, output int bad);
    start = 1'b1;
    tick;
    start = 1'b0;
    n = 0;
    bad = 0;
    while (!done && n < 200) begin
      if ({a, b} !== 4'(n / 3)) bad++;
      if (busy !== 1'b1) bad++;
      start = (n == restart_at);
      tick;
      n++;
    end
    start = 1'b0;
  endtask

  initial begin
    rst_n  = 1'b0;
    start  = 1'b0;
    abort  = 1'b0;
    start2 = 1'b0;
    abort2 = 1'b0;
    mode   = 0;
    tick;
    tick;
    check_all_zero("reset");
    rst_n = 1'b1;
    tick;

    // Ideal multiplier
    run_sweep(-1, cyc, seq_bad);
    check("ideal_done_cycle", cyc, 48);
    check("ideal_sequence", seq_bad, 0);
    check("ideal_busy_at_done", {31'd0, busy}, 32'd0);
    check("ideal_pass", {31'd0, pass}, 32'd1);
    check("ideal_err", {27'd0, err}, 32'd0);
    check("ideal_fail_seen", {31'd0, fail_seen}, 32'd0);
    check("ideal_last_ab", {28'd0, a, b}, 32'hF);
    repeat (3) tick;
    check("done_holds", {31'd0, done}, 32'd1);

    // z[3] stuck-at-0: only 3*3=9 loses bit 3, observed as 1
    mode = 1;
    run_sweep(-1, cyc, seq_bad);
    check("sa0_done_cycle", cyc, 48);
    check("sa0_err", {27'd0, err}, 32'd1);
    check("sa0_fail_a", {30'd0, fail_a}, 32'd3);
    check("sa0_fail_b", {30'd0, fail_b}, 32'd3);
    check("sa0_fail_z", {28'd0, fail_z}, 32'd1);
    check("sa0_pass", {31'd0, pass}, 32'd0);
    check("sa0_fail_seen", {31'd0, fail_seen}, 32'd1);

    // z[0] stuck-at-1: 12 of 16 products are even
    mode = 2;
    run_sweep(-1, cyc, seq_bad);
    check("sa1_done_cycle", cyc, 48);
    check("sa1_err", {27'd0, err}, 32'd12);
    check("sa1_first", {24'd0, fail_a, fail_b, fail_z}, 32'h001);
    check("sa1_pass", {31'd0, pass}, 32'd0);

    // start while busy is ignored; restart from DONE clears the counters
    mode = 0;
    run_sweep(10, cyc, seq_bad);
    check("restart_done_cycle", cyc, 48);
    check("restart_sequence", seq_bad, 0);
    check("restart_pass", {31'd0, pass}, 32'd1);
    check("restart_err_cleared", {27'd0, err}, 32'd0);
    check("restart_fail_cleared", {31'd0, fail_seen}, 32'd0);

    // abort together with start at cycle 20: vectors 0..5 checked, 5 even products
    mode  = 2;
    start = 1'b1;
    tick;
    start = 1'b0;
    repeat (20) tick;
    abort = 1'b1;
    start = 1'b1;
    tick;
    abort = 1'b0;
    start = 1'b0;
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_done", {31'd0, done}, 32'd0);
    check("abort_ab", {28'd0, a, b}, 32'd0);
    check("abort_err_kept", {27'd0, err}, 32'd5);
    check("abort_fail_kept", {31'd0, fail_seen}, 32'd1);
    repeat (3) tick;
    check("abort_stays_idle", {30'd0, busy, done}, 32'd0);

    // asynchronous reset mid-sweep, checked between clock edges
    start = 1'b1;
    tick;
    start = 1'b0;
    repeat (30) tick;
    check("pre_reset_busy", {31'd0, busy}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check_all_zero("async_reset");
    @(negedge clk);
    rst_n = 1'b1;
    tick;

    // SETTLE=1 instance with one-cycle-late z
    start2 = 1'b1;
    tick;
    start2 = 1'b0;
    cyc = 0;
    while (!done2 && cyc < 200) begin
      tick;
      cyc++;
    end
    check("s1_done_cycle", cyc, 32);
    check("s1_pass", {31'd0, pass2}, 32'd1);
    check("s1_err", {27'd0, err2}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
